// File: rtl/pipe_addsub_sm.sv
// ---------------------------------------------------------------------------
// pipe_addsub_sm
//
// Two-stage pipelined unsigned add/subtract unit that returns its result in
// sign-magnitude form. It is used for the exponent difference and exponent
// sum in the floating-point adder datapath.
//
//   Stage 1 : registers the raw WIDTH+1-bit sum or two's-complement
//             difference, together with the op select and the tag.
//   Stage 2 : converts the raw result to sign/magnitude and registers the
//             magnitude, sign, zero and swap flags and the tag.
//
// Both stages use valid/ready flow control. A stage advances whenever the
// stage after it is empty or is being drained. This gives one operation
// per cycle under backpressure without a skid buffer.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand/op/tag present
//   in_ready   unit accepts input this cycle (never depends on in_valid)
//   dataa      operand A, unsigned, WIDTH bits
//   datab      operand B, unsigned, WIDTH bits
//   add_sub    1 = A+B, 0 = A-B
//   in_tag     sideband tag, TAG_W bits
//   out_valid  result present
//   out_ready  downstream accepts result
//   answer     result magnitude, WIDTH+1 bits
//   sign12     1 = result negative (sub with A<B only)
//   zero       answer == 0
//   swap       sub with A<B, so the larger operand is B
//   out_tag    tag of this result
// ---------------------------------------------------------------------------
module pipe_addsub_sm #(
  parameter int WIDTH = 11,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dataa,
  input  logic [WIDTH-1:0] datab,
  input  logic             add_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   answer,
  output logic             sign12,
  output logic             zero,
  output logic             swap,
  output logic [TAG_W-1:0] out_tag
);

  // -------------------------------------------------------------------------
  // Flow control
  // -------------------------------------------------------------------------
  logic adv1;
  logic adv2;

  logic             s1_valid_q;
  logic [WIDTH:0]   s1_raw_q;
  logic             s1_add_q;
  logic [TAG_W-1:0] s1_tag_q;

  logic             s2_valid_q;
  logic [WIDTH:0]   s2_answer_q;
  logic             s2_sign_q;
  logic             s2_zero_q;
  logic             s2_swap_q;
  logic [TAG_W-1:0] s2_tag_q;

  // Stage 2 may take new data when it is empty or is being drained this
  // cycle. Stage 1 may take new data when it is empty or stage 2 advances.
  assign adv2     = !s2_valid_q || out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign in_ready = adv1;

  // -------------------------------------------------------------------------
  // Stage 1: raw arithmetic
  // -------------------------------------------------------------------------
  logic [WIDTH:0] s1_raw_d;

  // Zero-extending both operands keeps the add carry in bit WIDTH. For sub,
  // the same bit becomes the borrow of the WIDTH+1-bit difference.
  always_comb begin
    if (add_sub) begin
      s1_raw_d = {1'b0, dataa} + {1'b0, datab};
    end else begin
      s1_raw_d = {1'b0, dataa} - {1'b0, datab};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_raw_q   <= '0;
      s1_add_q   <= 1'b0;
      s1_tag_q   <= '0;
    end else if (adv1) begin
      // in_ready equals adv1, so inside this branch a valid input is an accept.
      s1_valid_q <= in_valid;
      s1_raw_q   <= s1_raw_d;
      s1_add_q   <= add_sub;
      s1_tag_q   <= in_tag;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2: sign-magnitude conversion
  // -------------------------------------------------------------------------
  logic           borrow;
  logic [WIDTH:0] s2_answer_d;
  logic           s2_zero_d;

  // A set MSB means negative only for a subtraction. For an add it is the
  // carry and belongs to the magnitude.
  assign borrow = !s1_add_q && s1_raw_q[WIDTH];

  always_comb begin
    if (borrow) begin
      // Two's-complement negation of A-B gives B-A. This cannot overflow
      // because |A-B| < 2^WIDTH.
      s2_answer_d = {(WIDTH+1){1'b0}} - s1_raw_q;
    end else begin
      s2_answer_d = s1_raw_q;
    end
  end

  // zero is registered, not decoded from answer, so it reads 0 in reset.
  assign s2_zero_d = (s2_answer_d == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q  <= 1'b0;
      s2_answer_q <= '0;
      s2_sign_q   <= 1'b0;
      s2_zero_q   <= 1'b0;
      s2_swap_q   <= 1'b0;
      s2_tag_q    <= '0;
    end else if (adv2) begin
      s2_valid_q  <= s1_valid_q;
      s2_answer_q <= s2_answer_d;
      s2_sign_q   <= borrow;
      s2_zero_q   <= s2_zero_d;
      s2_swap_q   <= borrow;
      s2_tag_q    <= s1_tag_q;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign out_valid = s2_valid_q;
  assign answer    = s2_answer_q;
  assign sign12    = s2_sign_q;
  assign zero      = s2_zero_q;
  assign swap      = s2_swap_q;
  assign out_tag   = s2_tag_q;

endmodule

// File: tb/tb_pipe_addsub_sm.sv
// ---------------------------------------------------------------------------
// tb_pipe_addsub_sm
//
// Directed and random stimulus for pipe_addsub_sm. Each accepted operation
// pushes its expected result to a queue. A monitor pops the queue and
// compares each result the unit delivers.
// ---------------------------------------------------------------------------
module tb_pipe_addsub_sm;

  localparam int WIDTH = 11;
  localparam int TAG_W = 4;

  typedef struct packed {
    logic [WIDTH:0]   ans;
    logic             sign;
    logic             zero;
    logic             swap;
    logic [TAG_W-1:0] tag;
  } res_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] dataa = '0;
  logic [WIDTH-1:0] datab = '0;
  logic             add_sub = 1'b0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH:0]   answer;
  logic             sign12;
  logic             zero;
  logic             swap;
  logic [TAG_W-1:0] out_tag;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  res_t sb[$];

  pipe_addsub_sm #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dataa     (dataa),
    .datab     (datab),
    .add_sub   (add_sub),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .answer    (answer),
    .sign12    (sign12),
    .zero      (zero),
    .swap      (swap),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: plain magnitude comparison, no borrow trick.
  function automatic res_t model(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b,
                                 logic op, logic [TAG_W-1:0] t);
    res_t e;
    e.tag  = t;
    e.sign = 1'b0;
    e.swap = 1'b0;
    if (op) begin
      e.ans = (WIDTH+1)'(a) + (WIDTH+1)'(b);
    end else if (a >= b) begin
      e.ans = (WIDTH+1)'(a - b);
    end else begin
      e.ans  = (WIDTH+1)'(b - a);
      e.sign = 1'b1;
      e.swap = 1'b1;
    end
    e.zero = (e.ans == '0);
    return e;
  endfunction

  function automatic res_t observed();
    res_t o;
    o.ans  = answer;
    o.sign = sign12;
    o.zero = zero;
    o.swap = swap;
    o.tag  = out_tag;
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Monitor: compare on an output transfer, record on an input accept.
  always @(negedge clk) begin
    res_t e;
    res_t o;
    if (rst_n && out_valid && out_ready) begin
      total++;
      assert (sb.size() > 0) else begin
        bad++;
        $error("FAIL unexpected_result observed=%0h expected=none", observed());
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        o = observed();
        total++;
        assert (o === e) else begin
          bad++;
          $error("FAIL result observed ans=%0d s=%b z=%b sw=%b tag=%0h expected ans=%0d s=%b z=%b sw=%b tag=%0h",
                 o.ans, o.sign, o.zero, o.swap, o.tag, e.ans, e.sign, e.zero, e.swap, e.tag);
        end
        $display("result ans=%0d sign=%b zero=%b swap=%b tag=%0h", o.ans, o.sign, o.zero, o.swap, o.tag);
      end
    end
    if (rst_n && in_valid && in_ready) begin
      sb.push_back(model(dataa, datab, add_sub, in_tag));
      $display("accept a=%0d b=%0d op=%b tag=%0h", dataa, datab, add_sub, in_tag);
    end
  end

  // Present one operation and hold it until accepted. Returns #1 after the
  // accepting edge with in_valid low.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic op, input logic [TAG_W-1:0] t);
    bit acc = 0;
    dataa = a; datab = b; add_sub = op; in_tag = t; in_valid = 1'b1;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      if (in_ready) acc = 1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    total++;
    assert (acc) else begin
      bad++;
      $error("FAIL accept_timeout observed=%0d expected=1", acc);
    end
  endtask

  task automatic wait_drain();
    int k = 0;
    while (sb.size() != 0 && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL drain_timeout observed=%0d expected=0", sb.size());
    end
  endtask

  initial begin
    res_t snap;
    int   c0;

    // Reset state
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_outputs",   32'(observed()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Max add with latency check
    send(11'd2047, 11'd2047, 1'b1, 4'h9);
    chk("lat_not_yet", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_answer", 32'(answer), 32'd4094);
    wait_drain();

    // Directed sub/add corner cases
    send(11'd5,    11'd9,    1'b0, 4'h1);
    send(11'd9,    11'd5,    1'b0, 4'h2);
    send(11'd0,    11'd2047, 1'b0, 4'h3);
    send(11'd9,    11'd9,    1'b0, 4'h4);
    send(11'd0,    11'd0,    1'b1, 4'h5);
    send(11'd2047, 11'd0,    1'b0, 4'h6);
    wait_drain();

    // 16 back-to-back random ops
    c0 = cyc;
    for (int i = 0; i < 16; i++) begin
      send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), TAG_W'(i));
    end
    chk("b2b_cycles", 32'(cyc - c0), 32'd16);
    wait_drain();

    // Backpressure: three ops with out_ready low
    out_ready = 1'b0;
    send(11'd100, 11'd300, 1'b0, 4'hA);
    send(11'd1000, 11'd24, 1'b1, 4'hB);
    chk("stall_in_ready_drop", 32'(in_ready), 32'd0);
    chk("stall_out_valid", 32'(out_valid), 32'd1);
    snap = observed();
    dataa = 11'd77; datab = 11'd77; add_sub = 1'b0; in_tag = 4'hC; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_hold", 32'(observed()), 32'(snap));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_drain();

    // Reset with both stages full during a stall
    out_ready = 1'b0;
    send(11'd50, 11'd60, 1'b1, 4'hD);
    send(11'd3,  11'd4,  1'b0, 4'hE);
    chk("pre_rst_full", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
    chk("mid_rst_outputs",   32'(observed()), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(11'd7, 11'd1, 1'b1, 4'h7);
    @(posedge clk);
    #1;
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_answer", 32'(answer), 32'd8);
    wait_drain();
    repeat (4) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
